// File: rtl/bp_lce_req_queue_if.sv
// Cache-side request and LCE-side request-header signals of the multi-outstanding request queue.
// Handshakes: cache_req is valid->yumi (yumi only when valid and ready_o); lce_req is valid/ready_and (transfer when both high, header held stable while valid waits).
interface bp_lce_req_queue_if #(
    parameter int paddr_width_p  = 40,
    parameter int dword_width_p  = 64,
    parameter int lce_id_width_p = 4,
    parameter int cce_id_width_p = 4,
    parameter int way_width_p    = 3
);
    logic [lce_id_width_p-1:0] lce_id_i;
    logic                      uc_mode_i;
    logic                      sync_done_i;
    logic                      ready_o;

    logic                      cache_req_v_i;
    logic                      cache_req_yumi_o;
    logic [1:0]                cache_req_type_i;
    logic [paddr_width_p-1:0]  cache_req_addr_i;
    logic [2:0]                cache_req_size_i;
    logic [dword_width_p-1:0]  cache_req_data_i;
    logic                      cache_req_metadata_v_i;
    logic [way_width_p-1:0]    cache_req_way_i;
    logic                      cache_req_complete_i;
    logic                      uc_store_complete_i;
    logic                      credits_full_o;
    logic                      credits_empty_o;

    logic                      lce_req_v_o;
    logic                      lce_req_ready_and_i;
    logic [1:0]                lce_req_type_o;
    logic [paddr_width_p-1:0]  lce_req_addr_o;
    logic [2:0]                lce_req_size_o;
    logic [way_width_p-1:0]    lce_req_way_o;
    logic                      lce_req_non_excl_o;
    logic [lce_id_width_p-1:0] lce_req_src_o;
    logic [cce_id_width_p-1:0] lce_req_dst_o;
    logic [dword_width_p-1:0]  lce_req_data_o;

    modport slave (
        input  lce_id_i, uc_mode_i, sync_done_i,
        input  cache_req_v_i, cache_req_type_i, cache_req_addr_i, cache_req_size_i,
        input  cache_req_data_i, cache_req_metadata_v_i, cache_req_way_i,
        input  cache_req_complete_i, uc_store_complete_i, lce_req_ready_and_i,
        output ready_o, cache_req_yumi_o, credits_full_o, credits_empty_o,
        output lce_req_v_o, lce_req_type_o, lce_req_addr_o, lce_req_size_o, lce_req_way_o,
        output lce_req_non_excl_o, lce_req_src_o, lce_req_dst_o, lce_req_data_o
    );

    modport master (
        output lce_id_i, uc_mode_i, sync_done_i,
        output cache_req_v_i, cache_req_type_i, cache_req_addr_i, cache_req_size_i,
        output cache_req_data_i, cache_req_metadata_v_i, cache_req_way_i,
        output cache_req_complete_i, uc_store_complete_i, lce_req_ready_and_i,
        input  ready_o, cache_req_yumi_o, credits_full_o, credits_empty_o,
        input  lce_req_v_o, lce_req_type_o, lce_req_addr_o, lce_req_size_o, lce_req_way_o,
        input  lce_req_non_excl_o, lce_req_src_o, lce_req_dst_o, lce_req_data_o
    );
endinterface

// File: rtl/bp_lce_req_queue.sv
// In-order FIFO of cache miss / uncached requests issued as LCE request headers,
// with per-entry replacement-way metadata and an outstanding-request credit counter.
module bp_lce_req_queue #(
    parameter int paddr_width_p      = 40,
    parameter int block_width_p      = 512,
    parameter int assoc_p            = 8,
    parameter int dword_width_p      = 64,
    parameter int lce_id_width_p     = 4,
    parameter int cce_id_width_p     = 4,
    parameter int num_cce_p          = 1,
    parameter int els_p              = 4,
    parameter int credits_p          = 8,
    parameter int non_excl_reads_p   = 0,
    parameter int metadata_latency_p = 0
) (
    input logic             clk_i,
    input logic             reset_i,
    bp_lce_req_queue_if.slave lce_if
);
    localparam int lg_assoc_lp       = (assoc_p > 1) ? $clog2(assoc_p) : 1;
    localparam int block_bytes_lp    = block_width_p / 8;
    localparam int lg_block_bytes_lp = $clog2(block_bytes_lp);
    localparam int ptr_w_lp          = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int cnt_w_lp          = $clog2(els_p + 1);
    localparam int out_w_lp          = $clog2(credits_p + 1);
    localparam bit meta_lat0_lp      = (metadata_latency_p == 0);

    if (metadata_latency_p > 1) begin : g_bad_latency
        $fatal(1, "bp_lce_req_queue: metadata_latency_p must be 0 or 1");
    end

    typedef struct packed {
        logic [1:0]               typ;
        logic [paddr_width_p-1:0] addr;
        logic [2:0]               size;
        logic [dword_width_p-1:0] data;
        logic [lg_assoc_lp-1:0]   way;
        logic                     meta_v;
    } entry_s;

    entry_s                mem_q [els_p];
    logic [ptr_w_lp-1:0]   wptr_q, rptr_q, meta_idx_q;
    logic [cnt_w_lp-1:0]   count_q;
    logic [out_w_lp-1:0]   outstanding_q;
    logic                  meta_pending_q;

    logic                  enq, deq, head_valid, head_miss, is_miss_in, meta_now, meta_late;
    logic [out_w_lp:0]     in_use, out_up;
    logic [1:0]            cred_dec;
    logic                  underflow;
    entry_s                head;

    function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
        return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + 1'b1;
    endfunction

    assign in_use     = (out_w_lp+1)'(outstanding_q) + (out_w_lp+1)'(count_q);
    assign lce_if.ready_o = (lce_if.uc_mode_i | lce_if.sync_done_i)
                          & (count_q != cnt_w_lp'(els_p))
                          & ~meta_pending_q
                          & (in_use < (out_w_lp+1)'(credits_p));
    assign enq        = lce_if.ready_o & lce_if.cache_req_v_i;
    assign lce_if.cache_req_yumi_o = enq;

    // Misses without metadata on the accept edge park here until the way arrives.
    assign is_miss_in = ~lce_if.cache_req_type_i[1];
    assign meta_now   = meta_lat0_lp & lce_if.cache_req_metadata_v_i;
    assign meta_late  = meta_pending_q & lce_if.cache_req_metadata_v_i;

    assign head       = mem_q[rptr_q];
    assign head_valid = (count_q != '0);
    assign head_miss  = ~head.typ[1];
    assign lce_if.lce_req_v_o = head_valid & head.meta_v;
    assign deq        = lce_if.lce_req_v_o & lce_if.lce_req_ready_and_i;

    assign cred_dec   = {1'b0, lce_if.cache_req_complete_i} + {1'b0, lce_if.uc_store_complete_i};
    assign out_up     = (out_w_lp+1)'(outstanding_q) + (out_w_lp+1)'(deq);
    assign underflow  = out_up < (out_w_lp+1)'(cred_dec);

    assign lce_if.credits_full_o  = (outstanding_q == out_w_lp'(credits_p));
    assign lce_if.credits_empty_o = (outstanding_q == '0) & ~head_valid;

    always_comb begin
        lce_if.lce_req_type_o     = '0;
        lce_if.lce_req_addr_o     = '0;
        lce_if.lce_req_size_o     = '0;
        lce_if.lce_req_way_o      = '0;
        lce_if.lce_req_non_excl_o = 1'b0;
        lce_if.lce_req_src_o      = '0;
        lce_if.lce_req_dst_o      = '0;
        lce_if.lce_req_data_o     = '0;
        if (head_valid) begin
            lce_if.lce_req_type_o     = head.typ;
            lce_if.lce_req_addr_o     = head_miss ? (head.addr & ~paddr_width_p'(block_bytes_lp - 1))
                                                  : head.addr;
            lce_if.lce_req_size_o     = head_miss ? 3'(lg_block_bytes_lp) : head.size;
            lce_if.lce_req_way_o      = head.way;
            lce_if.lce_req_non_excl_o = (head.typ == 2'd0) & (non_excl_reads_p != 0);
            lce_if.lce_req_src_o      = lce_if.lce_id_i;
            // Address-interleaved CCE selection; num_cce_p is a power of two.
            lce_if.lce_req_dst_o      = cce_id_width_p'((head.addr >> lg_block_bytes_lp)
                                                        & paddr_width_p'(num_cce_p - 1));
            lce_if.lce_req_data_o     = (head.typ == 2'd3) ? head.data : '0;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wptr_q        <= '0;
            rptr_q        <= '0;
            count_q       <= '0;
            outstanding_q <= '0;
        end else begin
            if (enq) wptr_q <= ptr_inc(wptr_q);
            if (deq) rptr_q <= ptr_inc(rptr_q);
            count_q       <= count_q + cnt_w_lp'(enq) - cnt_w_lp'(deq);
            outstanding_q <= underflow ? '0 : out_w_lp'(out_up - (out_w_lp+1)'(cred_dec));
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            meta_pending_q <= 1'b0;
            meta_idx_q     <= '0;
        end else if (enq && is_miss_in && !meta_now) begin
            meta_pending_q <= 1'b1;
            meta_idx_q     <= wptr_q;
        end else if (meta_late) begin
            meta_pending_q <= 1'b0;
        end
    end

    // Payload storage carries no reset; occupancy alone decides what is live.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem_q[wptr_q].typ    <= lce_if.cache_req_type_i;
            mem_q[wptr_q].addr   <= lce_if.cache_req_addr_i;
            mem_q[wptr_q].size   <= lce_if.cache_req_size_i;
            mem_q[wptr_q].data   <= lce_if.cache_req_data_i;
            mem_q[wptr_q].way    <= (is_miss_in && meta_now) ? lce_if.cache_req_way_i : '0;
            mem_q[wptr_q].meta_v <= ~is_miss_in | meta_now;
        end
        if (meta_late) begin
            mem_q[meta_idx_q].way    <= lce_if.cache_req_way_i;
            mem_q[meta_idx_q].meta_v <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) assert (!underflow) else $error("bp_lce_req_queue: outstanding credit underflow");
    end
endmodule

// File: tb/tb_bp_lce_req_queue.sv
// Randomised and directed stimulus for bp_lce_req_queue, checked by a scoreboard of expected
// LCE headers built from the request rules, plus per-cycle credit/ready expectations.
module tb_bp_lce_req_queue;
    localparam int PADDR = 40, DWORD = 64, LCE_W = 4, CCE_W = 4, WAY_W = 3;
    localparam int ELS = 4, CREDITS = 6, NUM_CCE = 2, BLOCK_BYTES = 64;
    localparam int HW = 2 + PADDR + 3 + WAY_W + 1 + LCE_W + CCE_W + DWORD;
    localparam logic [LCE_W-1:0] LCE_ID = 4'h9;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bp_lce_req_queue_if #(.paddr_width_p(PADDR), .dword_width_p(DWORD), .lce_id_width_p(LCE_W),
                          .cce_id_width_p(CCE_W), .way_width_p(WAY_W)) bus ();

    bp_lce_req_queue #(.paddr_width_p(PADDR), .block_width_p(512), .assoc_p(8), .dword_width_p(DWORD),
                       .lce_id_width_p(LCE_W), .cce_id_width_p(CCE_W), .num_cce_p(NUM_CCE), .els_p(ELS),
                       .credits_p(CREDITS), .non_excl_reads_p(1), .metadata_latency_p(1))
        dut (.clk_i(clk), .reset_i(rst), .lce_if(bus));

    int checks = 0;
    int failures = 0;
    logic [HW-1:0] exp_q[$];
    int occ_m = 0, out_m = 0;
    bit pend_m = 0;
    int env_mode = 0;        // 0 directed, 1 random, 2 drain
    bit dir_ready = 0, dir_cmp = 0, dir_ucs = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [HW-1:0] pack_hdr(input logic [1:0] t, input logic [PADDR-1:0] a,
                                               input logic [2:0] sz, input logic [WAY_W-1:0] w,
                                               input logic nx, input logic [LCE_W-1:0] s,
                                               input logic [CCE_W-1:0] d, input logic [DWORD-1:0] dat);
        return {t, a, sz, w, nx, s, d, dat};
    endfunction

    // Reference header: misses are block-aligned with block size code log2(64)=6.
    function automatic logic [HW-1:0] ref_hdr(input logic [1:0] t, input logic [PADDR-1:0] a,
                                              input logic [2:0] sz, input logic [DWORD-1:0] dat,
                                              input logic [WAY_W-1:0] w);
        bit miss;
        logic [PADDR-1:0] ea;
        miss = (t < 2);
        ea = miss ? (a / BLOCK_BYTES) * BLOCK_BYTES : a;
        return pack_hdr(t, ea, miss ? 3'd6 : sz, miss ? w : '0, t == 2'd0, LCE_ID,
                        CCE_W'((a / BLOCK_BYTES) % NUM_CCE), (t == 2'd3) ? dat : '0);
    endfunction

    function automatic logic [HW-1:0] act_hdr();
        return pack_hdr(bus.lce_req_type_o, bus.lce_req_addr_o, bus.lce_req_size_o, bus.lce_req_way_o,
                        bus.lce_req_non_excl_o, bus.lce_req_src_o, bus.lce_req_dst_o, bus.lce_req_data_o);
    endfunction

    // Predictor: per-cycle ready/credit expectations and expected-header pushes.
    always @(negedge clk) begin
        #1;
        if (!rst) begin
            bit rdy, acc, deq;
            rdy = (bus.uc_mode_i | bus.sync_done_i) && (occ_m < ELS) && !pend_m && (out_m + occ_m < CREDITS);
            acc = rdy && bus.cache_req_v_i;
            deq = bus.lce_req_v_o && bus.lce_req_ready_and_i;
            check("ready_o", bus.ready_o, rdy);
            check("yumi", bus.cache_req_yumi_o, acc);
            check("credits_full", bus.credits_full_o, out_m == CREDITS);
            check("credits_empty", bus.credits_empty_o, (out_m == 0) && (occ_m == 0));
            if (acc) exp_q.push_back(ref_hdr(bus.cache_req_type_i, bus.cache_req_addr_i, bus.cache_req_size_i,
                                             bus.cache_req_data_i, bus.cache_req_way_i));
            if (pend_m && bus.cache_req_metadata_v_i) pend_m = 0;
            if (acc && bus.cache_req_type_i < 2) pend_m = 1;
            occ_m = occ_m + int'(acc) - int'(deq);
            if (occ_m < 0) occ_m = 0;
            out_m = out_m + int'(deq) - int'(bus.cache_req_complete_i) - int'(bus.uc_store_complete_i);
            if (out_m < 0) out_m = 0;
        end
    end

    // Monitor: compare presented headers against the scoreboard.
    always @(negedge clk) begin
        if (!rst && bus.lce_req_v_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL hdr_unexpected actual=%0h required=none", act_hdr());
            end else if (bus.lce_req_ready_and_i) begin
                check("lce_req_hdr", act_hdr(), exp_q.pop_front());
            end else begin
                check("lce_req_hdr_hold", act_hdr(), exp_q[0]);
            end
        end
    end

    // Network-ready and completion driver.
    always @(posedge clk) begin
        bit c, u;
        #2;
        case (env_mode)
            1: begin
                bus.lce_req_ready_and_i = ($urandom_range(0, 3) != 0);
                c = (out_m >= 1) && ($urandom_range(0, 2) == 0);
                u = (out_m >= 1 + int'(c)) && ($urandom_range(0, 2) == 0);
                bus.cache_req_complete_i = c;
                bus.uc_store_complete_i  = u;
            end
            2: begin
                bus.lce_req_ready_and_i  = 1'b1;
                bus.cache_req_complete_i = (out_m >= 1);
                bus.uc_store_complete_i  = (out_m >= 2);
            end
            default: begin
                bus.lce_req_ready_and_i  = dir_ready;
                bus.cache_req_complete_i = dir_cmp;
                bus.uc_store_complete_i  = dir_ucs;
            end
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] t, input logic [PADDR-1:0] a, input logic [2:0] sz,
                        input logic [DWORD-1:0] dat, input logic [WAY_W-1:0] w);
        int n;
        bus.cache_req_v_i    = 1'b1;
        bus.cache_req_type_i = t;
        bus.cache_req_addr_i = a;
        bus.cache_req_size_i = sz;
        bus.cache_req_data_i = dat;
        bus.cache_req_way_i  = w;
        for (n = 0; n < 300; n++) begin
            @(negedge clk);
            if (bus.cache_req_yumi_o) break;
        end
        check("send_accept_timeout", n < 300, 1'b1);
        tick();
        bus.cache_req_v_i = 1'b0;
        if (t < 2) begin
            bus.cache_req_metadata_v_i = 1'b1;
            tick();
            bus.cache_req_metadata_v_i = 1'b0;
        end
    endtask

    task automatic wait_drain(input int budget, input bit need_credits_zero);
        int n;
        for (n = 0; n < budget; n++) begin
            @(posedge clk);
            if (exp_q.size() == 0 && occ_m == 0 && (!need_credits_zero || out_m == 0)) break;
        end
        check("drain_timeout", n < budget, 1'b1);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int yumi_cnt;
        logic [63:0] r;
        bus.lce_id_i = LCE_ID;
        bus.uc_mode_i = 0; bus.sync_done_i = 0;
        bus.cache_req_v_i = 0; bus.cache_req_type_i = 0; bus.cache_req_addr_i = 0;
        bus.cache_req_size_i = 0; bus.cache_req_data_i = 0; bus.cache_req_metadata_v_i = 0;
        bus.cache_req_way_i = 0; bus.cache_req_complete_i = 0; bus.uc_store_complete_i = 0;
        bus.lce_req_ready_and_i = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_v_o", bus.lce_req_v_o, 1'b0);
        check("rst_ready", bus.ready_o, 1'b0);
        check("rst_full", bus.credits_full_o, 1'b0);
        check("rst_empty", bus.credits_empty_o, 1'b1);
        check("rst_addr", bus.lce_req_addr_o, '0);
        tick();
        rst = 1'b0;

        // No sync and not uncached: nothing may be accepted.
        bus.cache_req_v_i = 1'b1;
        bus.cache_req_type_i = 2'd2;
        yumi_cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.cache_req_yumi_o) yumi_cnt++;
        end
        check("nosync_yumi_count", yumi_cnt, 0);
        tick();
        bus.cache_req_v_i = 1'b0;
        bus.sync_done_i = 1'b1;

        // Fill queue with network stalled, then release.
        for (int i = 0; i < ELS; i++) send(2'd2, 40'h10_0000_0000 + 40'(i * 'h48), 3'd3, 64'h0, 3'd0);
        @(negedge clk);
        check("ready_queue_full", bus.ready_o, 1'b0);
        tick();
        dir_ready = 1'b1;
        wait_drain(50, 0);

        // Two more issued: outstanding reaches the credit limit.
        send(2'd2, 40'h00_0000_0208, 3'd2, 64'h0, 3'd0);
        send(2'd2, 40'h00_0000_0244, 3'd1, 64'h0, 3'd0);
        wait_drain(50, 0);
        @(negedge clk);
        check("credits_full_at_limit", bus.credits_full_o, 1'b1);
        check("ready_at_credit_limit", bus.ready_o, 1'b0);

        // Both completion strobes together retire two per cycle.
        tick();
        dir_cmp = 1'b1; dir_ucs = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        dir_cmp = 1'b0; dir_ucs = 1'b0;
        @(negedge clk);
        check("credits_empty_after_dual_complete", bus.credits_empty_o, 1'b1);
        check("credits_full_after_dual_complete", bus.credits_full_o, 1'b0);

        // Latency-1 miss_store: issue waits for the metadata edge.
        tick();
        bus.cache_req_v_i = 1'b1; bus.cache_req_type_i = 2'd1;
        bus.cache_req_addr_i = 40'h00_8000_0123; bus.cache_req_way_i = 3'd5;
        @(negedge clk);
        check("miss_accept", bus.cache_req_yumi_o, 1'b1);
        check("miss_no_bypass", bus.lce_req_v_o, 1'b0);
        tick();
        bus.cache_req_v_i = 1'b0; bus.cache_req_metadata_v_i = 1'b1;
        @(negedge clk);
        check("miss_waits_meta", bus.lce_req_v_o, 1'b0);
        tick();
        bus.cache_req_metadata_v_i = 1'b0;
        @(negedge clk);
        check("miss_v_o", bus.lce_req_v_o, 1'b1);
        check("miss_addr", bus.lce_req_addr_o, 40'h00_8000_0100);
        check("miss_type", bus.lce_req_type_o, 2'd1);
        check("miss_way", bus.lce_req_way_o, 3'd5);
        check("miss_size", bus.lce_req_size_o, 3'd6);
        tick();
        dir_ready = 1'b0;

        // uc_store payload.
        send(2'd3, 40'h00_1234_5677, 3'd2, 64'hDEAD_BEEF, 3'd0);
        @(negedge clk);
        check("ucst_v_o", bus.lce_req_v_o, 1'b1);
        check("ucst_type", bus.lce_req_type_o, 2'd3);
        check("ucst_data", bus.lce_req_data_o, 64'hDEAD_BEEF);
        check("ucst_addr", bus.lce_req_addr_o, 40'h00_1234_5677);
        check("ucst_non_excl", bus.lce_req_non_excl_o, 1'b0);
        check("ucst_size", bus.lce_req_size_o, 3'd2);
        tick();
        dir_ready = 1'b1;
        wait_drain(50, 0);

        // Asynchronous reset while a header is held.
        tick();
        dir_ready = 1'b0;
        send(2'd2, 40'h00_0000_0400, 3'd3, 64'h0, 3'd0);
        @(negedge clk);
        check("pre_reset_v_o", bus.lce_req_v_o, 1'b1);
        #3;
        rst = 1'b1;
        exp_q.delete();
        occ_m = 0; out_m = 0; pend_m = 0;
        #1;
        check("async_reset_v_o", bus.lce_req_v_o, 1'b0);
        @(negedge clk);
        check("reset_v_o_next", bus.lce_req_v_o, 1'b0);
        check("reset_empty_next", bus.credits_empty_o, 1'b1);
        tick();
        rst = 1'b0;

        // Randomised traffic.
        env_mode = 1;
        repeat (150) begin
            r = {$urandom, $urandom};
            send(2'($urandom_range(0, 3)), r[PADDR-1:0], 3'($urandom_range(0, 3)),
                 {$urandom, $urandom}, 3'($urandom_range(0, 7)));
            repeat ($urandom_range(0, 2)) tick();
        end
        env_mode = 2;
        wait_drain(2000, 1);
        @(negedge clk);
        check("final_credits_empty", bus.credits_empty_o, 1'b1);
        check("final_ready", bus.ready_o, 1'b1);
        check("final_scoreboard_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
